// File: rtl/fifo_out_arbiter_if.sv
// Bundle of the input-FIFO heads and the downstream channel served by one router output port.
interface fifo_out_arbiter_if #(
  parameter int unsigned N_IN  = 5,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned W     = 32
);
  logic [N_IN-1:0]   in_empty;
  logic [N_IN-1:0]   in_want;
  logic [N_IN-1:0]   in_tail;
  logic [N_IN*W-1:0] in_items;
  logic [N_IN-1:0]   in_read;
  logic              out_full;
  logic              out_write;
  logic [W-1:0]      out_item;
  logic [IDX_W-1:0]  grant_idx;
  logic              locked;

  modport master (
    input  in_empty, in_want, in_tail, in_items, out_full,
    output in_read, out_write, out_item, grant_idx, locked
  );

  modport slave (
    output in_empty, in_want, in_tail, in_items, out_full,
    input  in_read, out_write, out_item, grant_idx, locked
  );
endinterface

// File: rtl/fifo_out_arbiter.sv
// NoC output-port scheduler: round-robin between input FIFOs with a wormhole lock
// held for the whole packet; pops the winner and registers its flit downstream.
module fifo_out_arbiter #(
  parameter int unsigned N_IN  = 5,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  fifo_out_arbiter_if.master  bus
);
  localparam int unsigned LAST = N_IN - 1;

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_rr_nxt;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [IDX_W-1:0]   w_gnt;
  logic [IDX_W-1:0]   w_off;
  logic [IDX_W-1:0]   w_rr_win;
  logic [IDX_W:0]     w_sum;
  logic               w_gnt_vld;
  logic               r_out_write;
  logic [W-1:0]       r_out_item;
  logic [W-1:0]       w_item;
  logic [N_IN-1:0]    w_req;
  logic [2*N_IN-1:0]  w_dbl;
  logic               w_any_req;
  logic               w_owner_req;

  assign w_req       = ~bus.in_empty & bus.in_want;
  assign w_any_req   = |w_req;
  assign w_owner_req = w_req[r_grant_idx];
  assign w_dbl       = {w_req, w_req} >> r_rr_ptr;

  // Lowest set bit of the rotated request vector is the first requester at or after rr_ptr
  always_comb begin
    w_off = '0;
    for (int k = int'(N_IN) - 1; k >= 0; k--) begin
      if (w_dbl[k]) w_off = IDX_W'(k);
    end
  end

  always_comb begin
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W+1)'(N_IN)) w_sum = w_sum - (IDX_W+1)'(N_IN);
    w_rr_win = w_sum[IDX_W-1:0];
  end

  // Next state and grant; a tail flit releases the port and advances the pointer past its owner
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_vld   = 1'b0;
    w_gnt       = r_grant_idx;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (!bus.out_full && w_any_req) begin
          w_gnt_vld = 1'b1;
          w_gnt     = w_rr_win;
        end
      end
      S_LOCKED: begin
        if (!bus.out_full && w_owner_req) w_gnt_vld = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_gnt_vld) begin
      if (bus.in_tail[w_gnt]) begin
        w_state_nxt = S_IDLE;
        w_rr_nxt    = (w_gnt == IDX_W'(LAST)) ? '0 : w_gnt + IDX_W'(1);
      end else begin
        w_state_nxt = S_LOCKED;
      end
    end
  end

  always_comb begin
    bus.in_read = '0;
    if (w_gnt_vld && !reset) bus.in_read[w_gnt] = 1'b1;
  end

  always_comb begin
    w_item = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (IDX_W'(i) == w_gnt) w_item = bus.in_items[i*int'(W) +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_out_write <= 1'b0;
      r_out_item  <= '0;
    end else begin
      r_rr_ptr    <= w_rr_nxt;
      r_out_write <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_out_item  <= w_item;
        r_grant_idx <= w_gnt;
      end
    end
  end

  assign bus.out_write = r_out_write;
  assign bus.out_item  = r_out_item;
  assign bus.grant_idx = r_grant_idx;
  assign bus.locked    = (r_state == S_LOCKED);
endmodule
